// File: rtl/mem_rd_arbiter.sv
// Read-channel arbiter sharing one burst memory port between I-cache and D-cache refills.
// Optional MEM_ARB_RR_EN selects round-robin arbitration; default is fixed priority to D-cache.
module mem_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              from_ic_rd_req_valid,
  input  logic [ADDR_W-1:0] from_ic_rd_req_addr,
  output logic              to_ic_rd_req_ready,
  output logic              to_ic_rd_rsp_valid,
  output logic [DATA_W-1:0] to_ic_rd_rsp_data,
  output logic              to_ic_rd_rsp_last,
  input  logic              from_ic_rd_rsp_ready,
  input  logic              from_dc_rd_req_valid,
  input  logic [ADDR_W-1:0] from_dc_rd_req_addr,
  output logic              to_dc_rd_req_ready,
  output logic              to_dc_rd_rsp_valid,
  output logic [DATA_W-1:0] to_dc_rd_rsp_data,
  output logic              to_dc_rd_rsp_last,
  input  logic              from_dc_rd_rsp_ready,
  output logic              to_mem_rd_req_valid,
  output logic [ADDR_W-1:0] to_mem_rd_req_addr,
  input  logic              from_mem_rd_req_ready,
  input  logic              from_mem_rd_rsp_valid,
  input  logic [DATA_W-1:0] from_mem_rd_rsp_data,
  input  logic              from_mem_rd_rsp_last,
  output logic              to_mem_rd_rsp_ready
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          owner_reg, owner_next;   // one-hot: bit 0 = IC, bit 1 = DC
  logic [ADDR_W-1:0]   addr_reg, addr_next;

  logic [1:0]              req_valid_m, grant, req_ready_m;
  logic [1:0]              rsp_ready_m, rsp_valid_m, rsp_last_m;
  logic [1:0][DATA_W-1:0]  rsp_data_m;
  logic                    in_idle, in_rsp, beat_hs;

  assign req_valid_m = {from_dc_rd_req_valid, from_ic_rd_req_valid};
  assign rsp_ready_m = {from_dc_rd_rsp_ready, from_ic_rd_rsp_ready};
  assign in_idle     = (state_reg == IDLE);
  assign in_rsp      = (state_reg == RSP);

`ifdef MEM_ARB_RR_EN
  logic prio_reg;   // 1: D-cache wins a tie, 0: I-cache wins a tie

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_reg <= 1'b1;
    end else if (in_idle && (|req_valid_m)) begin
      prio_reg <= grant[0];
    end
  end

  assign grant[1] = req_valid_m[1] & (~req_valid_m[0] | prio_reg);
`else
  assign grant[1] = req_valid_m[1];
`endif
  assign grant[0] = req_valid_m[0] & ~grant[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= 2'b00;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
    end
  end

  assign to_mem_rd_rsp_ready = in_rsp & (|(owner_reg & rsp_ready_m));
  assign beat_hs = from_mem_rd_rsp_valid & to_mem_rd_rsp_ready;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid_m) begin
          state_next = REQ;
          owner_next = grant;
          addr_next  = grant[1] ? from_dc_rd_req_addr : from_ic_rd_req_addr;
        end
      end
      REQ: begin
        if (from_mem_rd_req_ready) state_next = RSP;
      end
      RSP: begin
        if (beat_hs && from_mem_rd_rsp_last) begin
          state_next = IDLE;
          owner_next = 2'b00;
        end
      end
      default: begin
        state_next = IDLE;
        owner_next = 2'b00;
      end
    endcase
  end

  // Beats are steered only to the owner and only while a burst is in flight.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign req_ready_m[gi] = rst & in_idle & grant[gi];
    assign rsp_valid_m[gi] = in_rsp & owner_reg[gi] & from_mem_rd_rsp_valid;
    assign rsp_last_m[gi]  = in_rsp & owner_reg[gi] & from_mem_rd_rsp_last;
    assign rsp_data_m[gi]  = (in_rsp & owner_reg[gi]) ? from_mem_rd_rsp_data : '0;
  end

  assign to_ic_rd_req_ready  = req_ready_m[0];
  assign to_ic_rd_rsp_valid  = rsp_valid_m[0];
  assign to_ic_rd_rsp_data   = rsp_data_m[0];
  assign to_ic_rd_rsp_last   = rsp_last_m[0];
  assign to_dc_rd_req_ready  = req_ready_m[1];
  assign to_dc_rd_rsp_valid  = rsp_valid_m[1];
  assign to_dc_rd_rsp_data   = rsp_data_m[1];
  assign to_dc_rd_rsp_last   = rsp_last_m[1];
  assign to_mem_rd_req_valid = (state_reg == REQ);
  assign to_mem_rd_req_addr  = addr_reg;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Randomized bench for mem_rd_arbiter against a transaction-level model of grants and bursts.
// Honours MEM_ARB_RR_EN the same way as the design.
module tb_mem_rd_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              from_ic_rd_req_valid = 1'b0;
  logic [ADDR_W-1:0] from_ic_rd_req_addr = '0;
  logic              to_ic_rd_req_ready;
  logic              to_ic_rd_rsp_valid;
  logic [DATA_W-1:0] to_ic_rd_rsp_data;
  logic              to_ic_rd_rsp_last;
  logic              from_ic_rd_rsp_ready = 1'b0;
  logic              from_dc_rd_req_valid = 1'b0;
  logic [ADDR_W-1:0] from_dc_rd_req_addr = '0;
  logic              to_dc_rd_req_ready;
  logic              to_dc_rd_rsp_valid;
  logic [DATA_W-1:0] to_dc_rd_rsp_data;
  logic              to_dc_rd_rsp_last;
  logic              from_dc_rd_rsp_ready = 1'b0;
  logic              to_mem_rd_req_valid;
  logic [ADDR_W-1:0] to_mem_rd_req_addr;
  logic              from_mem_rd_req_ready = 1'b0;
  logic              from_mem_rd_rsp_valid = 1'b0;
  logic [DATA_W-1:0] from_mem_rd_rsp_data = '0;
  logic              from_mem_rd_rsp_last = 1'b0;
  logic              to_mem_rd_rsp_ready;

  always #5 clk = ~clk;

  mem_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .from_ic_rd_req_valid  (from_ic_rd_req_valid),
    .from_ic_rd_req_addr   (from_ic_rd_req_addr),
    .to_ic_rd_req_ready    (to_ic_rd_req_ready),
    .to_ic_rd_rsp_valid    (to_ic_rd_rsp_valid),
    .to_ic_rd_rsp_data     (to_ic_rd_rsp_data),
    .to_ic_rd_rsp_last     (to_ic_rd_rsp_last),
    .from_ic_rd_rsp_ready  (from_ic_rd_rsp_ready),
    .from_dc_rd_req_valid  (from_dc_rd_req_valid),
    .from_dc_rd_req_addr   (from_dc_rd_req_addr),
    .to_dc_rd_req_ready    (to_dc_rd_req_ready),
    .to_dc_rd_rsp_valid    (to_dc_rd_rsp_valid),
    .to_dc_rd_rsp_data     (to_dc_rd_rsp_data),
    .to_dc_rd_rsp_last     (to_dc_rd_rsp_last),
    .from_dc_rd_rsp_ready  (from_dc_rd_rsp_ready),
    .to_mem_rd_req_valid   (to_mem_rd_req_valid),
    .to_mem_rd_req_addr    (to_mem_rd_req_addr),
    .from_mem_rd_req_ready (from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid (from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data  (from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last  (from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready   (to_mem_rd_rsp_ready)
  );

  int passed_cnt = 0;
  int total_cnt  = 0;

  // Model state: outstanding requests per master and the tie-break preference.
  logic              ic_pend = 1'b0, dc_pend = 1'b0;
  logic [ADDR_W-1:0] ic_a = '0, dc_a = '0;
  logic              prio_dc_m = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) passed_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic dc_wins(input logic icv, input logic dcv, input logic pr);
`ifdef MEM_ARB_RR_EN
    return dcv && (!icv || pr);
`else
    return dcv && (pr || !pr);
`endif
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a, input int b);
    return (a + 32'(b * 4)) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return $urandom() & 32'hFFFF_FFE0;
  endfunction

  // Non-pending requesters drive garbage addresses so a latched address must stay put.
  task automatic drive_reqs();
    from_ic_rd_req_valid = ic_pend;
    from_ic_rd_req_addr  = ic_pend ? ic_a : $urandom();
    from_dc_rd_req_valid = dc_pend;
    from_dc_rd_req_addr  = dc_pend ? dc_a : $urandom();
  endtask

  task automatic churn_reqs();
    if (!ic_pend && $urandom_range(0, 2) == 0) begin ic_pend = 1'b1; ic_a = rand_addr(); end
    if (!dc_pend && $urandom_range(0, 2) == 0) begin dc_pend = 1'b1; dc_a = rand_addr(); end
    if (ic_pend && $urandom_range(0, 3) == 0) ic_a = rand_addr();
    if (dc_pend && $urandom_range(0, 3) == 0) dc_a = rand_addr();
    drive_reqs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ic_req_ready"}, to_ic_rd_req_ready, 1'b0);
    check({tag, "_dc_req_ready"}, to_dc_rd_req_ready, 1'b0);
    check({tag, "_mem_req_valid"}, to_mem_rd_req_valid, 1'b0);
    check({tag, "_mem_req_addr"}, to_mem_rd_req_addr, '0);
    check({tag, "_mem_rsp_ready"}, to_mem_rd_rsp_ready, 1'b0);
    check({tag, "_rsp_valids"}, {to_ic_rd_rsp_valid, to_dc_rd_rsp_valid}, 2'b00);
    check({tag, "_rsp_lasts"}, {to_ic_rd_rsp_last, to_dc_rd_rsp_last}, 2'b00);
  endtask

  // Called at posedge+1 with the DUT idle.
  task automatic idle_stray();
    drive_reqs();
    from_mem_rd_rsp_valid = 1'b1;
    from_mem_rd_rsp_last  = 1'($urandom_range(0, 1));
    from_mem_rd_rsp_data  = $urandom();
    from_ic_rd_rsp_ready  = 1'b1;
    from_dc_rd_rsp_ready  = 1'b1;
    @(negedge clk);
    check("stray_mem_rsp_ready", to_mem_rd_rsp_ready, 1'b0);
    check("stray_rsp_valids", {to_ic_rd_rsp_valid, to_dc_rd_rsp_valid}, 2'b00);
    @(posedge clk); #1;
    from_mem_rd_rsp_valid = 1'b0;
    @(negedge clk);
    check("stray_still_idle", to_mem_rd_req_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic do_burst(input int id, input int max_stall, input bit rst_at_3);
    logic              w_dc, own_rdy, mv, hs;
    logic [ADDR_W-1:0] exp_addr;
    int                stall, beat, guard;
    if (!ic_pend && !dc_pend) begin
      idle_stray();
      case ($urandom_range(0, 2))
        0: begin ic_pend = 1'b1; ic_a = rand_addr(); end
        1: begin dc_pend = 1'b1; dc_a = rand_addr(); end
        default: begin
          ic_pend = 1'b1; ic_a = rand_addr();
          dc_pend = 1'b1; dc_a = rand_addr();
        end
      endcase
    end
    drive_reqs();
    @(negedge clk);
    w_dc = dc_wins(ic_pend, dc_pend, prio_dc_m);
    exp_addr = w_dc ? dc_a : ic_a;
    check("ic_req_ready", to_ic_rd_req_ready, ic_pend && !w_dc);
    check("dc_req_ready", to_dc_rd_req_ready, w_dc);
    check("idle_mem_req_valid", to_mem_rd_req_valid, 1'b0);
`ifdef MEM_ARB_RR_EN
    prio_dc_m = !w_dc;
`endif
    @(posedge clk); #1;
    if (w_dc) dc_pend = 1'b0; else ic_pend = 1'b0;
    churn_reqs();

    stall = $urandom_range(0, max_stall);
    $display("burst %0d owner=%s addr=%08h stall=%0d", id, w_dc ? "DC" : "IC", exp_addr, stall);
    for (int i = 0; i <= stall; i++) begin
      from_mem_rd_req_ready = (i == stall);
      @(negedge clk);
      check("req_mem_valid", to_mem_rd_req_valid, 1'b1);
      check("req_mem_addr", to_mem_rd_req_addr, exp_addr);
      check("req_busy_readys", {to_ic_rd_req_ready, to_dc_rd_req_ready}, 2'b00);
      check("req_mem_rsp_ready", to_mem_rd_rsp_ready, 1'b0);
      @(posedge clk); #1;
      churn_reqs();
    end
    from_mem_rd_req_ready = 1'b0;

    beat  = 0;
    guard = 0;
    while (beat < BEATS && guard < 200) begin
      guard++;
      mv = ($urandom_range(0, 3) != 0);
      from_mem_rd_rsp_valid = mv;
      from_mem_rd_rsp_data  = mv ? beat_data(exp_addr, beat) : $urandom();
      from_mem_rd_rsp_last  = mv ? (beat == BEATS - 1) : 1'($urandom_range(0, 1));
      from_ic_rd_rsp_ready  = ($urandom_range(0, 3) != 0);
      from_dc_rd_rsp_ready  = ($urandom_range(0, 3) != 0);
      if (rst_at_3 && beat == 3) begin
        from_mem_rd_rsp_valid = 1'b1;
        from_mem_rd_rsp_data  = beat_data(exp_addr, beat);
        from_mem_rd_rsp_last  = 1'b0;
        #2 rst = 1'b0;
        #1 check_all_zero("rst_mid");
        $display("reset asserted during beat 3 of burst %0d", id);
        @(posedge clk); #1;
        check_all_zero("rst_held");
        rst = 1'b1;
        from_mem_rd_rsp_valid = 1'b0;
        ic_pend = 1'b0;
        dc_pend = 1'b0;
        prio_dc_m = 1'b1;
        drive_reqs();
        return;
      end
      own_rdy = w_dc ? from_dc_rd_rsp_ready : from_ic_rd_rsp_ready;
      @(negedge clk);
      check("own_rsp_valid", w_dc ? to_dc_rd_rsp_valid : to_ic_rd_rsp_valid, mv);
      check("other_rsp_valid", w_dc ? to_ic_rd_rsp_valid : to_dc_rd_rsp_valid, 1'b0);
      check("mem_rsp_ready", to_mem_rd_rsp_ready, own_rdy);
      check("rsp_busy_readys", {to_ic_rd_req_ready, to_dc_rd_req_ready}, 2'b00);
      if (mv) begin
        check("own_rsp_data", w_dc ? to_dc_rd_rsp_data : to_ic_rd_rsp_data, beat_data(exp_addr, beat));
        check("own_rsp_last", w_dc ? to_dc_rd_rsp_last : to_ic_rd_rsp_last, beat == BEATS - 1);
      end
      hs = mv && own_rdy;
      @(posedge clk); #1;
      if (hs) beat++;
      churn_reqs();
    end
    check("burst_done_in_budget", guard < 200, 1'b1);
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_last  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    from_ic_rd_req_valid = 1'b1;
    from_dc_rd_req_valid = 1'b1;
    from_mem_rd_rsp_valid = 1'b1;
    #1 check_all_zero("reset");
    from_ic_rd_req_valid = 1'b0;
    from_dc_rd_req_valid = 1'b0;
    from_mem_rd_rsp_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      do_burst(n, (n == 7) ? 5 : 3, n == 15);
      if (n == 15) begin
        ic_pend = 1'b1;
        ic_a = 32'h0000_1000;
      end
    end
    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed_cnt, total_cnt);
    $fatal(1);
  end

endmodule
